// File: rtl/exec_latency_unit.sv
// exec_latency_unit: multi-latency execute stage feeding the single CDB port.
// In-flight uops live in a small slot pool with per-slot countdowns.
// Ready slots are written back one per cycle by round robin.
// Optional feature macro: EXEC_DIV_BLOCK_EN. When defined, the divider is non-pipelined,
// so only one DIV may be in flight at a time.
module exec_latency_unit #(
  parameter int unsigned NUM_SLOTS = 4,
  parameter int unsigned PRF_W     = 6,
  parameter int unsigned OP_W      = 5,
  parameter int unsigned ALU_LAT   = 1,
  parameter int unsigned MUL_LAT   = 3,
  parameter int unsigned DIV_LAT   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic [OP_W-1:0]  issue_opcode,
  input  logic [PRF_W-1:0] issue_dest_prf,
  output logic             issue_stall,
  output logic             exec_done,
  output logic [PRF_W-1:0] exec_dest_prf
);

  localparam int unsigned MAX_AM  = (ALU_LAT > MUL_LAT) ? ALU_LAT : MUL_LAT;
  localparam int unsigned MAX_LAT = (MAX_AM > DIV_LAT) ? MAX_AM : DIV_LAT;
  localparam int unsigned CNT_W   = ($clog2(MAX_LAT) < 1) ? 1 : $clog2(MAX_LAT);
  localparam int unsigned IDX_W   = $clog2(NUM_SLOTS);

  logic [NUM_SLOTS-1:0] r_valid;
  logic [PRF_W-1:0]     r_tag [NUM_SLOTS];
  logic [CNT_W-1:0]     r_cnt [NUM_SLOTS];
  logic [IDX_W-1:0]     r_rr;

  logic                 w_is_mul;
  logic                 w_is_div;
  logic [CNT_W-1:0]     w_lat_m1;
  logic [NUM_SLOTS-1:0] w_ready;
  logic                 w_alloc_found;
  logic [IDX_W-1:0]     w_alloc_idx;
  logic                 w_gnt_found;
  logic [IDX_W-1:0]     w_gnt_idx;
  logic                 w_accept;
  logic                 w_unused_op;

  assign w_is_mul    = (issue_opcode[4:3] == 2'b01);
  assign w_is_div    = (issue_opcode[4:3] == 2'b10);
  assign w_unused_op = ^issue_opcode;

`ifdef EXEC_DIV_BLOCK_EN
  logic [NUM_SLOTS-1:0] r_is_div;
  logic                 w_div_busy;
  assign w_div_busy  = |(r_valid & r_is_div);
  // Full pool, or a second DIV while the divider is occupied.
  assign issue_stall = (&r_valid) | (w_is_div & w_div_busy);
`else
  // Stall only when every slot is occupied.
  assign issue_stall = &r_valid;
`endif

  assign w_accept = issue_valid & ~issue_stall;

  // Initial countdown for the presented uop class.
  always_comb begin
    w_lat_m1 = CNT_W'(ALU_LAT - 1);
    if (w_is_mul)      w_lat_m1 = CNT_W'(MUL_LAT - 1);
    else if (w_is_div) w_lat_m1 = CNT_W'(DIV_LAT - 1);
  end

  // Ready vector and lowest-index free slot.
  always_comb begin
    w_ready       = '0;
    w_alloc_found = 1'b0;
    w_alloc_idx   = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_ready[i] = r_valid[i] && (r_cnt[i] == '0);
    end
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_alloc_found = 1'b1;
        w_alloc_idx   = IDX_W'(i);
      end
    end
  end

  // Round-robin writeback grant starting at r_rr.
  always_comb begin
    logic [IDX_W-1:0] cand;
    cand        = '0;
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
      cand = r_rr + IDX_W'(k);
      if (!w_gnt_found && w_ready[cand]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = cand;
      end
    end
  end

  // Slot pool, countdowns, writeback output and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid       <= '0;
      r_rr          <= '0;
      exec_done     <= 1'b0;
      exec_dest_prf <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_tag[i] <= '0;
        r_cnt[i] <= '0;
      end
`ifdef EXEC_DIV_BLOCK_EN
      r_is_div      <= '0;
`endif
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (r_valid[i] && (r_cnt[i] != '0)) r_cnt[i] <= r_cnt[i] - CNT_W'(1);
      end
      exec_done <= w_gnt_found;
      if (w_gnt_found) begin
        r_valid[w_gnt_idx] <= 1'b0;
        exec_dest_prf      <= r_tag[w_gnt_idx];
        r_rr               <= w_gnt_idx + IDX_W'(1);
      end
      // Allocation target is always a currently-free slot, never the granted one.
      if (w_accept && w_alloc_found) begin
        r_valid[w_alloc_idx] <= 1'b1;
        r_tag[w_alloc_idx]   <= issue_dest_prf;
        r_cnt[w_alloc_idx]   <= w_lat_m1;
`ifdef EXEC_DIV_BLOCK_EN
        r_is_div[w_alloc_idx] <= w_is_div;
`endif
      end
    end
  end

endmodule

// File: tb/tb_exec_latency_unit.sv
// Directed self-checking bench for exec_latency_unit (default parameters).
module tb_exec_latency_unit;

  localparam logic [4:0] OP_ALU = 5'b00000;
  localparam logic [4:0] OP_MUL = 5'b01000;
  localparam logic [4:0] OP_DIV = 5'b10000;

  logic       clk;
  logic       reset;
  logic       issue_valid;
  logic [4:0] issue_opcode;
  logic [5:0] issue_dest_prf;
  logic       issue_stall;
  logic       exec_done;
  logic [5:0] exec_dest_prf;

  int n_checks = 0;
  int n_errors = 0;

  exec_latency_unit dut (
    .clk            (clk),
    .reset          (reset),
    .issue_valid    (issue_valid),
    .issue_opcode   (issue_opcode),
    .issue_dest_prf (issue_dest_prf),
    .issue_stall    (issue_stall),
    .exec_done      (exec_done),
    .exec_dest_prf  (exec_dest_prf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] op, input logic [5:0] dest);
    issue_valid    = v;
    issue_opcode   = op;
    issue_dest_prf = dest;
  endtask

  // Advance one edge, then check the writeback pulse (and tag when pulsing).
  task automatic tick_chk(input string tag, input logic exp_done, input logic [5:0] exp_dest);
    tick();
    check_eq({tag, "_done"}, 32'(exec_done), 32'(exp_done));
    if (exp_done) check_eq({tag, "_dest"}, 32'(exec_dest_prf), 32'(exp_dest));
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, OP_ALU, 6'h00);

    // 1: reset state and quiet release
    tick();
    tick();
    check_eq("rst_done", 32'(exec_done), 32'd0);
    check_eq("rst_dest", 32'(exec_dest_prf), 32'd0);
    check_eq("rst_stall", 32'(issue_stall), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) tick_chk("rst_idle", 1'b0, 6'h00);

    // 2: single ALU, one-cycle pulse; tag holds afterwards
    drive(1'b1, OP_ALU, 6'h05);
    tick_chk("alu_n", 1'b0, 6'h00);
    drive(1'b0, OP_ALU, 6'h00);
    tick_chk("alu_n1", 1'b1, 6'h05);
    tick_chk("alu_n2", 1'b0, 6'h00);
    check_eq("alu_hold", 32'(exec_dest_prf), 32'h05);

    // 3: MUL then ALU complete out of order
    drive(1'b1, OP_MUL, 6'h0A);
    tick_chk("ooo_n", 1'b0, 6'h00);
    drive(1'b1, OP_ALU, 6'h0B);
    tick_chk("ooo_n1", 1'b0, 6'h00);
    drive(1'b0, OP_ALU, 6'h00);
    tick_chk("ooo_n2", 1'b1, 6'h0B);
    tick_chk("ooo_n3", 1'b1, 6'h0A);
    tick_chk("ooo_n4", 1'b0, 6'h00);

    // 4: contention; pointer sits at slot 1 so the ALU in slot 1 wins first
    drive(1'b1, OP_MUL, 6'h21);
    tick_chk("rr_n", 1'b0, 6'h00);
    drive(1'b0, OP_ALU, 6'h00);
    tick_chk("rr_n1", 1'b0, 6'h00);
    drive(1'b1, OP_ALU, 6'h22);
    tick_chk("rr_n2", 1'b0, 6'h00);
    drive(1'b0, OP_ALU, 6'h00);
    tick_chk("rr_n3", 1'b1, 6'h22);
    tick_chk("rr_n4", 1'b1, 6'h21);
    tick_chk("rr_n5", 1'b0, 6'h00);

    // 5: fill the pool (DIV + 3 MUL), stall, refill after first grant
    drive(1'b1, OP_DIV, 6'h31);
    check_eq("full_st0", 32'(issue_stall), 32'd0);
    tick_chk("full_n", 1'b0, 6'h00);
    drive(1'b1, OP_MUL, 6'h32);
    tick_chk("full_n1", 1'b0, 6'h00);
    drive(1'b1, OP_MUL, 6'h33);
    tick_chk("full_n2", 1'b0, 6'h00);
    drive(1'b1, OP_MUL, 6'h34);
    check_eq("full_st3", 32'(issue_stall), 32'd0);
    tick_chk("full_n3", 1'b0, 6'h00);
    drive(1'b1, OP_ALU, 6'h35);
    check_eq("full_stall", 32'(issue_stall), 32'd1);
    tick_chk("full_n4", 1'b1, 6'h32);
    check_eq("full_unstall", 32'(issue_stall), 32'd0);
    tick_chk("full_n5", 1'b1, 6'h33);
    drive(1'b0, OP_ALU, 6'h00);
    tick_chk("full_n6", 1'b1, 6'h34);
    tick_chk("full_n7", 1'b1, 6'h35);
    tick_chk("full_n8", 1'b1, 6'h31);
    tick_chk("full_n9", 1'b0, 6'h00);

    // 6: back-to-back DIVs
    drive(1'b1, OP_DIV, 6'h11);
    tick_chk("div_n", 1'b0, 6'h00);
    drive(1'b1, OP_DIV, 6'h12);
`ifdef EXEC_DIV_BLOCK_EN
    check_eq("div_blk_st", 32'(issue_stall), 32'd1);
    for (int i = 1; i < 8; i++) tick_chk("div_blk_wait", 1'b0, 6'h00);
    check_eq("div_blk_st7", 32'(issue_stall), 32'd1);
    tick_chk("div_blk_n8", 1'b1, 6'h11);
    check_eq("div_blk_free", 32'(issue_stall), 32'd0);
    tick_chk("div_blk_n9", 1'b0, 6'h00);
    drive(1'b0, OP_ALU, 6'h00);
    for (int i = 10; i < 17; i++) tick_chk("div_blk_run", 1'b0, 6'h00);
    tick_chk("div_blk_n17", 1'b1, 6'h12);
    tick_chk("div_blk_n18", 1'b0, 6'h00);
`else
    check_eq("div_pipe_st", 32'(issue_stall), 32'd0);
    tick_chk("div_pipe_n1", 1'b0, 6'h00);
    drive(1'b0, OP_ALU, 6'h00);
    for (int i = 2; i < 8; i++) tick_chk("div_pipe_run", 1'b0, 6'h00);
    tick_chk("div_pipe_n8", 1'b1, 6'h11);
    tick_chk("div_pipe_n9", 1'b1, 6'h12);
    tick_chk("div_pipe_n10", 1'b0, 6'h00);
`endif

    // 7: reset with three MULs in flight drops them
    drive(1'b1, OP_MUL, 6'h41);
    tick_chk("drop_n", 1'b0, 6'h00);
    drive(1'b1, OP_MUL, 6'h42);
    tick_chk("drop_n1", 1'b0, 6'h00);
    drive(1'b1, OP_MUL, 6'h43);
    tick_chk("drop_n2", 1'b0, 6'h00);
    drive(1'b0, OP_ALU, 6'h00);
    reset = 1'b1;
    tick_chk("drop_rst", 1'b0, 6'h00);
    check_eq("drop_stall", 32'(issue_stall), 32'd0);
    check_eq("drop_dest", 32'(exec_dest_prf), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) tick_chk("drop_idle", 1'b0, 6'h00);
    check_eq("drop_dest_end", 32'(exec_dest_prf), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
